// File: rtl/fft_frame_feeder.sv
// Feeds left-channel samples from the sample FIFO read side into the FFT sink,
// framing them into FFT_POINTS-long packets behind a two-entry skid buffer.
module fft_frame_feeder #(
  parameter int FFT_POINTS = 1024,
  parameter int OUT_W      = 16,
  parameter int PTS_W      = $clog2(FFT_POINTS) + 1
) (
  input  logic             CLOCK_50,
  input  logic             AUD_ADCLRCK,
  input  logic [31:0]      fifo_q,
  input  logic             fifo_rdempty,
  output logic             fifo_rdreq,
  input  logic             sink_ready,
  output logic             sink_valid,
  output logic             sink_sop,
  output logic             sink_eop,
  output logic [OUT_W-1:0] sink_real,
  output logic [OUT_W-1:0] sink_imag,
  output logic [1:0]       sink_error,
  output logic [PTS_W-1:0] fftpts_in,
  output logic             frame_done
);

  localparam int IDX_W = $clog2(FFT_POINTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_POINTS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       occ_reg, occ_next;
  logic             inflight_reg, inflight_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             head_reg, head_next;
  logic             tail_reg, tail_next;
  logic             frame_done_reg;
  logic [OUT_W-1:0] buf_reg [2];

  logic             pop;
  logic             push;
  logic [2:0]       pending;
  logic             unused_bits;

  assign pop  = sink_valid & sink_ready;
  assign push = inflight_reg;

  // Occupancy after this cycle's push/pop; also the committed-sample count used for read gating.
  assign pending    = {1'b0, occ_reg} + {2'b00, inflight_reg} - {2'b00, pop};
  assign fifo_rdreq = !AUD_ADCLRCK & !fifo_rdempty & (pending < 3'd2);

  assign sink_valid = (occ_reg != 2'd0);
  assign sink_real  = buf_reg[head_reg];
  assign sink_sop   = sink_valid & (idx_reg == '0);
  assign sink_eop   = sink_valid & (idx_reg == LAST_IDX);
  assign sink_imag  = '0;
  assign sink_error = 2'b00;
  assign fftpts_in  = PTS_W'(FFT_POINTS);
  assign frame_done = frame_done_reg;

  assign unused_bits = ^{fifo_q, pending[2]};

  always_comb begin
    occ_next      = pending[1:0];
    inflight_next = fifo_rdreq;
    head_next     = head_reg ^ pop;
    tail_next     = tail_reg ^ push;
    idx_next      = idx_reg;
    state_next    = state_reg;
    if (pop) begin
      idx_next = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
    end
    case (state_reg)
      IDLE: begin
        if (push) state_next = STREAM;
      end
      STREAM: begin
        if ((occ_next == 2'd0) && (idx_next == '0) && !inflight_next) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge AUD_ADCLRCK) begin
    if (AUD_ADCLRCK) begin
      state_reg      <= IDLE;
      occ_reg        <= 2'd0;
      inflight_reg   <= 1'b0;
      idx_reg        <= '0;
      head_reg       <= 1'b0;
      tail_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      occ_reg        <= occ_next;
      inflight_reg   <= inflight_next;
      idx_reg        <= idx_next;
      head_reg       <= head_next;
      tail_reg       <= tail_next;
      frame_done_reg <= pop & sink_eop;
    end
  end

  // Each buffer slot captures the truncated FIFO word when the tail points at it.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      always_ff @(posedge CLOCK_50 or posedge AUD_ADCLRCK) begin
        if (AUD_ADCLRCK) begin
          buf_reg[gi] <= '0;
        end else if (push && (tail_reg == 1'(gi))) begin
          buf_reg[gi] <= fifo_q[31 -: OUT_W];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed bench for fft_frame_feeder: a behavioural FIFO feeds the DUT and a
// monitor records every accepted sample for comparison against a vector table.
module tb_fft_frame_feeder;

  localparam int N  = 8;
  localparam int OW = 16;
  localparam int PW = 4;

  logic          CLOCK_50 = 1'b0;
  logic          AUD_ADCLRCK = 1'b1;
  logic [31:0]   fifo_q = '0;
  logic          fifo_rdempty;
  logic          fifo_rdreq;
  logic          sink_ready = 1'b1;
  logic          sink_valid, sink_sop, sink_eop, frame_done;
  logic [OW-1:0] sink_real, sink_imag;
  logic [1:0]    sink_error;
  logic [PW-1:0] fftpts_in;

  fft_frame_feeder #(.FFT_POINTS(N), .OUT_W(OW)) dut (
    .CLOCK_50(CLOCK_50), .AUD_ADCLRCK(AUD_ADCLRCK), .fifo_q(fifo_q),
    .fifo_rdempty(fifo_rdempty), .fifo_rdreq(fifo_rdreq), .sink_ready(sink_ready),
    .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_real(sink_real), .sink_imag(sink_imag), .sink_error(sink_error),
    .fftpts_in(fftpts_in), .frame_done(frame_done)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Show-ahead-off FIFO: data appears the cycle after the read request.
  logic [31:0] fmem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_rdempty = (rd_ptr == wr_ptr);
  always @(posedge CLOCK_50) begin
    if (fifo_rdreq) begin
      fifo_q <= fmem[rd_ptr[7:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  typedef struct {
    logic [31:0] q;
    logic [15:0] re;
    logic        sop;
    logic        eop;
    bit          drop;
  } vec_t;

  typedef struct {
    logic [15:0] re;
    logic        sop;
    logic        eop;
    int          cyc;
  } rec_t;

  vec_t vec [45];
  rec_t act [$];
  int   ai = 0;
  int   errors = 0;
  int   checks = 0;
  int   fd_cnt = 0;
  bit   toggle = 0;
  bit   hold_low = 0;
  int   ph = 0;
  logic [3:0] pat = 4'b1001;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, got, req);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
      if (hold_low) sink_ready = 1'b0;
      else if (toggle) sink_ready = pat[3 - (ph % 4)];
      else sink_ready = 1'b1;
      ph++;
    end
  endtask

  task automatic wait_acc(input int target, input int budget);
    int b;
    b = budget;
    while (act.size() < target && b > 0) begin
      cycles(1);
      b--;
    end
    if (act.size() < target) begin
      checks++;
      errors++;
      $display("FAIL wait_acc timeout: got %0d transfers required %0d", act.size(), target);
    end
  endtask

  task automatic push_seg(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      fmem[wr_ptr[7:0]] = vec[i].q;
      wr_ptr++;
    end
  endtask

  task automatic check_seg(input int lo, input int hi, input bit contig);
    for (int i = lo; i <= hi; i++) begin
      if (!vec[i].drop) begin
        if (ai >= act.size()) begin
          checks++;
          errors++;
          $display("FAIL missing_xfer vec %0d: got none required real=%h", i, vec[i].re);
        end else begin
          chk($sformatf("real[%0d]", i), 32'(act[ai].re), 32'(vec[i].re));
          chk($sformatf("sop[%0d]", i), 32'(act[ai].sop), 32'(vec[i].sop));
          chk($sformatf("eop[%0d]", i), 32'(act[ai].eop), 32'(vec[i].eop));
          if (contig && i > lo) chk($sformatf("contig[%0d]", i), act[ai].cyc - act[ai-1].cyc, 1);
          ai++;
        end
      end
    end
  endtask

  task automatic pulse_reset();
    @(posedge CLOCK_50);
    #1;
    AUD_ADCLRCK = 1'b1;
    cycles(2);
    AUD_ADCLRCK = 1'b0;
  endtask

  initial begin
    int rel;
    int fd0;
    int base;
    bit prev_stall;
    bit fd_exp;
    logic [15:0] prev_real;
    prev_stall = 0;
    fd_exp = 0;
    prev_real = '0;

    for (int k = 0; k < 20; k++) begin
      vec[k].q = 32'(k) << 16; vec[k].re = 16'(k);
      vec[k].sop = (k % 8 == 0); vec[k].eop = (k % 8 == 7); vec[k].drop = 0;
    end
    for (int k = 0; k < 8; k++) begin
      vec[20+k].q = 32'(100 + k) << 16; vec[20+k].re = 16'(100 + k);
      vec[20+k].sop = (k == 0); vec[20+k].eop = (k == 7); vec[20+k].drop = 0;
    end
    for (int k = 0; k < 13; k++) begin
      vec[28+k].q = 32'(200 + k) << 16; vec[28+k].re = 16'(200 + k);
      vec[28+k].sop = (k == 0) || (k == 5); vec[28+k].eop = (k == 12);
      vec[28+k].drop = (k == 3) || (k == 4);
    end
    vec[41] = '{32'h8000FFFF, 16'h8000, 1'b1, 1'b0, 1'b0};
    vec[42] = '{32'h7FFF8000, 16'h7FFF, 1'b0, 1'b0, 1'b0};
    vec[43] = '{32'h12345678, 16'h1234, 1'b0, 1'b0, 1'b0};
    vec[44] = '{32'hFFFF0001, 16'hFFFF, 1'b0, 1'b0, 1'b0};

    fork
      forever begin
        @(negedge CLOCK_50);
        if (AUD_ADCLRCK) begin
          prev_stall = 0;
          fd_exp = 0;
        end else begin
          if (prev_stall) begin
            chk("stall_valid", 32'(sink_valid), 32'd1);
            chk("stall_real", 32'(sink_real), 32'(prev_real));
          end
          if (fd_exp || frame_done) chk("frame_done", 32'(frame_done), 32'(fd_exp));
          if (sink_valid) chk("occ_max", 32'(dut.occ_reg <= 2'd2), 32'd1);
          if (frame_done) fd_cnt++;
          if (sink_valid && sink_ready) begin
            act.push_back('{sink_real, sink_sop, sink_eop, cyc});
            $display("xfer %0d: cyc=%0d real=%h sop=%b eop=%b", act.size() - 1, cyc, sink_real, sink_sop, sink_eop);
          end
          fd_exp = sink_valid & sink_ready & sink_eop;
          prev_stall = sink_valid & !sink_ready;
          prev_real = sink_real;
        end
      end
    join_none

    // Reset held with a non-empty FIFO.
    push_seg(0, 19);
    repeat (5) begin
      @(negedge CLOCK_50);
      chk("rst_rdreq", 32'(fifo_rdreq), 32'd0);
      chk("rst_valid", 32'(sink_valid), 32'd0);
      chk("rst_sop", 32'(sink_sop), 32'd0);
      chk("rst_eop", 32'(sink_eop), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_real", 32'(sink_real), 32'd0);
      chk("rst_imag", 32'(sink_imag), 32'd0);
      chk("rst_error", 32'(sink_error), 32'd0);
      chk("rst_fftpts", 32'(fftpts_in), 32'd8);
    end

    // Continuous streaming, 20 samples.
    @(posedge CLOCK_50);
    #1;
    AUD_ADCLRCK = 1'b0;
    rel = cyc;
    fd0 = fd_cnt;
    wait_acc(20, 100);
    cycles(5);
    if (act.size() > 0) chk("first_latency", act[0].cyc, rel + 2);
    check_seg(0, 19, 1);
    chk("frames_stream", fd_cnt - fd0, 2);
    chk("extra_stream", act.size(), ai);

    // Same stimulus with sink_ready pattern 1,0,0,1.
    pulse_reset();
    fd0 = fd_cnt;
    toggle = 1;
    ph = 0;
    push_seg(0, 19);
    wait_acc(ai + 20, 200);
    cycles(6);
    toggle = 0;
    check_seg(0, 19, 0);
    chk("frames_toggle", fd_cnt - fd0, 2);
    chk("extra_toggle", act.size(), ai);

    // FIFO runs dry after five samples of a frame.
    pulse_reset();
    base = ai;
    push_seg(20, 24);
    cycles(15);
    chk("gap_count", act.size(), base + 5);
    chk("gap_valid", 32'(sink_valid), 32'd0);
    chk("gap_sop", 32'(sink_sop), 32'd0);
    push_seg(25, 27);
    wait_acc(base + 8, 40);
    cycles(4);
    if (act.size() >= base + 6) chk("gap_len", 32'(act[base+5].cyc - act[base+4].cyc > 10), 32'd1);
    check_seg(20, 27, 0);

    // Reset mid-frame with two samples buffered under backpressure.
    pulse_reset();
    fd0 = fd_cnt;
    push_seg(28, 40);
    wait_acc(ai + 3, 40);
    sink_ready = 1'b0;
    hold_low = 1;
    cycles(4);
    chk("pre_rst_valid", 32'(sink_valid), 32'd1);
    #3;
    AUD_ADCLRCK = 1'b1;
    #1;
    chk("async_valid", 32'(sink_valid), 32'd0);
    chk("async_sop", 32'(sink_sop), 32'd0);
    chk("async_eop", 32'(sink_eop), 32'd0);
    chk("async_real", 32'(sink_real), 32'd0);
    chk("async_rdreq", 32'(fifo_rdreq), 32'd0);
    chk("async_frame_done", 32'(frame_done), 32'd0);
    hold_low = 0;
    cycles(2);
    AUD_ADCLRCK = 1'b0;
    wait_acc(ai + 8, 60);
    cycles(4);
    check_seg(28, 40, 0);
    chk("frames_reset", fd_cnt - fd0, 1);
    chk("extra_reset", act.size(), ai);

    // MSB truncation of full-width words.
    push_seg(41, 44);
    wait_acc(ai + 4, 30);
    cycles(3);
    check_seg(41, 44, 0);
    chk("extra_trunc", act.size(), ai);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t required completion", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fft_frame_feeder.md
# fft_frame_feeder

Streams left-channel audio samples out of the dual-clock sample FIFO, on its CLOCK_50 read side, into the Avalon-ST sink port of the tuner FFT. It drives the FIFO read request and converts each 32-bit sample to the FFT input width. It frames the stream into fixed-length packets with start/end-of-packet markers and honours FFT backpressure without dropping or duplicating samples. It sits between the sample FIFO (`q`, `rdempty`, `rdreq`) and the FFT core (`sink_*`, `fftpts_in`).

## Interface
- FFT_POINTS, 1024: samples per frame; power of two, 8..4096.
- OUT_W, 16: FFT input sample width; 2..32.
- PTS_W, $clog2(FFT_POINTS)+1: width of `fftpts_in`.

Ports:
- CLOCK_50  in  1  clock; all logic on its rising edge.
- AUD_ADCLRCK  in  1  reset, asynchronous, active-high.
- fifo_q  in  32  FIFO read data; two's-complement sample, valid the cycle after `fifo_rdreq`.
- fifo_rdempty  in  1  FIFO read-side empty flag.
- fifo_rdreq  out  1  FIFO read request; combinational from registered state and inputs.
- sink_ready  in  1  FFT ready; readyLatency 0.
- sink_valid  out  1  sample valid.
- sink_sop  out  1  first sample of a frame.
- sink_eop  out  1  last sample of a frame.
- sink_real  out  OUT_W  `fifo_q[31:32-OUT_W]` (MSB truncation, no rounding).
- sink_imag  out  OUT_W  constant 0.
- sink_error  out  2  constant 2'b00.
- fftpts_in  out  PTS_W  constant FFT_POINTS.
- frame_done  out  1  one-cycle pulse when the eop sample is accepted.

## Operation
- Two-entry output buffer (occupancy `occ` 0..2) plus one in-flight flag `inflight` (FIFO read issued last cycle).
- pop = sink_valid & sink_ready.
- fifo_rdreq = !fifo_rdempty & ((occ + inflight - pop) < 2). This guarantees no buffer overflow and sustains 1 sample/cycle.
- When `inflight` is set, `fifo_q` is truncated and written to the buffer tail in that cycle. A push and a pop may happen in the same cycle: occ is unchanged and FIFO order is preserved.
- sink_valid = (occ != 0). sink_real shows the buffer head.
- Sample counter `idx` counts 0..FFT_POINTS-1 and advances only on pop. It wraps to 0 after the eop pop.
- sink_sop = sink_valid & (idx == 0). sink_eop = sink_valid & (idx == FFT_POINTS-1).
- State machine:
  - IDLE: occ = 0 and idx = 0.
  - STREAM: idx != 0, or occ != 0.
  - IDLE -> STREAM on the first push. STREAM -> IDLE when the eop pop leaves occ = 0 and inflight = 0; otherwise it stays in STREAM with the next frame's sop.
- FIFO empty mid-frame: sink_valid drops. idx holds. The frame resumes later with no extra sop. Gaps inside a packet are legal for the sink.
- sink_ready low: the buffer holds and sink_real is stable. No more than 2 samples are buffered plus none in flight. fifo_rdreq deasserts.
- frame_done is registered, high the cycle after the eop pop.
- Reset asserted (any time, including mid-frame):
  - occ = 0, inflight = 0, idx = 0, state IDLE, frame_done = 0.
  - Buffered and in-flight samples are discarded.
  - The first sample after reset is tagged sop.

## Timing
- Reset values:
  - sink_valid, sink_sop, sink_eop, frame_done, fifo_rdreq = 0.
  - sink_real = 0, sink_imag = 0, sink_error = 0.
  - fftpts_in = FFT_POINTS.
- Latency: rdreq in cycle n -> sample captured at end of n+1 -> sink_valid high in cycle n+2.
- Throughput: 1 sample/cycle while FIFO is non-empty and sink_ready = 1.
- A frame with no stalls occupies exactly FFT_POINTS consecutive valid cycles.
- No combinational path from sink_ready to sink_valid/sink_real. sink_ready -> fifo_rdreq is permitted.

## Test plan
- FFT_POINTS=8; FIFO preloaded with samples 0x00010000·k (k=0..19); sink_ready=1:
  - sink_real = 0,1,2,…,19 on consecutive cycles.
  - sop on k=0, 8, 16; eop on k=7, 15.
  - frame_done pulses twice.
- Same stimulus, sink_ready toggled 1,0,0,1 repeating:
  - Identical accepted sequence and sop/eop positions.
  - sink_real stable while stalled; occ never exceeds 2.
- FIFO empties after 5 samples of an 8-point frame; 3 more arrive 10 cycles later:
  - sink_valid low for the gap.
  - No sop on sample 5; eop on sample 7.
- Reset pulsed after 3 accepted samples with 2 buffered:
  - All outputs return to reset values asynchronously.
  - The next accepted sample carries sop and idx restarts at 0.
- fifo_q = 0x8000FFFF, OUT_W=16: sink_real = 0x8000. fifo_q = 0x7FFF8000: sink_real = 0x7FFF.
- Reset held 5 cycles:
  - sink_imag = 0, sink_error = 0, fftpts_in = 8.
  - fifo_rdreq = 0 even with the FIFO non-empty.
